// File: rtl/dac161_pkg.sv
// Shared definitions for the DAC161S055 update scheduler:
// FSM state encoding, frame source tags, DAC command bytes,
// SPI frame width and small helper functions.
// Macro DAC161_LDAC_PULSE_EN adds the LDAC pulse state.
package dac161_pkg;

   localparam int FRAME_W = 24;

   localparam logic [7:0] DAC_CFG_CMD  = 8'h08;
   localparam logic [7:0] DAC_DATA_CMD = 8'h01;

   typedef enum logic [2:0] {
      ST_INIT_WAIT,
      ST_CFG_ISSUE,
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT_HI,
      ST_WAIT_LO,
      ST_GAP
`ifdef DAC161_LDAC_PULSE_EN
      ,
      ST_LDAC
`endif
   } state_t;

   // Owner of the frame currently on the wire.
   typedef enum logic [1:0] {
      SRC_CFG,
      SRC_REQ0,
      SRC_REQ1
   } src_t;

   function automatic int max3(
      input int a,
      input int b,
      input int c
   );
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

   function automatic logic [FRAME_W-1:0] mk_frame(
      input logic [7:0]  cmd,
      input logic [15:0] word
   );
      return {cmd, word};
   endfunction

endpackage

// File: rtl/dac161_update_sched_rr_arb2.sv
// Two-way round-robin arbiter with a last_grant register.
// Ports:
//   clk, rst    clock, asynchronous active-low reset
//   req0, req1  request lines
//   take        the grant is consumed this cycle
//   gnt0, gnt1  one-hot (or zero) combinational grant
// last_grant resets to 1 so requester 0 wins the first tie.
module rr_arb2
   import dac161_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic req0,
   input  logic req1,
   input  logic take,
   output logic gnt0,
   output logic gnt1
);

   logic last_grant;

   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (req0 && req1) begin
         gnt0 = last_grant;
         gnt1 = !last_grant;
      end else begin
         gnt0 = req0;
         gnt1 = req1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_grant <= 1'b1;
      end else if (take && (gnt0 || gnt1)) begin
         last_grant <= gnt1;
      end
   end

endmodule

// File: rtl/dac161_update_sched.sv
// Sequencer/arbiter in front of the 24-bit SPI DAC161S055 master.
// After reset it sends one configuration frame, then shares the
// master between two setpoint requesters (round-robin), enforces
// a chip-select gap and owns CLRB/LDACB.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   req0/data0/ack0     requester 0 (ack is a 1-cycle pulse)
//   req1/data1/ack1     requester 1
//   spi_start/spi_data  start pulse and frame to the SPI master
//   spi_busy            SPI master busy
//   clrb, ldacb         DAC control pins
//   init_done           configuration frame completed
//   err                 sticky busy-rise timeout
// Macro DAC161_LDAC_PULSE_EN: pulse ldacb low for 2 cycles after
// each gap; otherwise ldacb is held low after reset release.
module dac161_update_sched
   import dac161_pkg::*;
#(
   parameter int          INIT_CYCLES = 1000,
   parameter int          GAP_CYCLES  = 16,
   parameter logic [7:0]  CFG_CMD     = DAC_CFG_CMD,
   parameter logic [15:0] CFG_WORD    = 16'h0000,
   parameter logic [7:0]  DATA_CMD    = DAC_DATA_CMD,
   parameter int          BUSY_TO     = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req0,
   input  logic [15:0]        data0,
   output logic               ack0,
   input  logic               req1,
   input  logic [15:0]        data1,
   output logic               ack1,
   output logic               spi_start,
   output logic [FRAME_W-1:0] spi_data,
   input  logic               spi_busy,
   output logic               clrb,
   output logic               ldacb,
   output logic               init_done,
   output logic               err
);

   localparam int CNT_MAX =
      max3(INIT_CYCLES, GAP_CYCLES, BUSY_TO);
   localparam int CW = $clog2(CNT_MAX) + 1;

   state_t        state;
   src_t          src;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_inc;
   logic          gnt0;
   logic          gnt1;
   logic          take;

   // Saturating increment: the counter never wraps.
   assign cnt_inc = (&cnt) ? cnt : cnt + CW'(1);

   assign clrb = 1'b1;

   // A foreign master holding busy blocks any new grant.
   assign take = (state == ST_IDLE) && init_done &&
                 !spi_busy && (req0 || req1);

   rr_arb2 u_arb (
      .clk  (clk),
      .rst  (rst),
      .req0 (req0),
      .req1 (req1),
      .take (take),
      .gnt0 (gnt0),
      .gnt1 (gnt1)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_INIT_WAIT;
         src       <= SRC_CFG;
         cnt       <= '0;
         spi_start <= 1'b0;
         spi_data  <= '0;
         ack0      <= 1'b0;
         ack1      <= 1'b0;
         init_done <= 1'b0;
         err       <= 1'b0;
         ldacb     <= 1'b1;
      end else begin
         spi_start <= 1'b0;
         ack0      <= 1'b0;
         ack1      <= 1'b0;
`ifdef DAC161_LDAC_PULSE_EN
`else
         ldacb     <= 1'b0;
`endif
         unique case (state)
            ST_INIT_WAIT: begin
               if (cnt == CW'(INIT_CYCLES)) begin
                  state     <= ST_CFG_ISSUE;
                  src       <= SRC_CFG;
                  spi_data  <= mk_frame(CFG_CMD, CFG_WORD);
                  spi_start <= 1'b1;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            ST_IDLE: begin
               if (take) begin
                  state     <= ST_ISSUE;
                  spi_start <= 1'b1;
                  if (gnt1) begin
                     src      <= SRC_REQ1;
                     spi_data <= mk_frame(DATA_CMD, data1);
                  end else begin
                     src      <= SRC_REQ0;
                     spi_data <= mk_frame(DATA_CMD, data0);
                  end
               end
            end
            ST_CFG_ISSUE,
            ST_ISSUE: begin
               // The start cycle counts as the first timeout cycle.
               cnt   <= CW'(1);
               state <= ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
               if (spi_busy) begin
                  state <= ST_WAIT_LO;
               end else if (cnt_inc >= CW'(BUSY_TO)) begin
                  err   <= 1'b1;
                  cnt   <= '0;
                  state <= ST_GAP;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            ST_WAIT_LO: begin
               if (!spi_busy) begin
                  unique case (src)
                     SRC_REQ0: ack0      <= 1'b1;
                     SRC_REQ1: ack1      <= 1'b1;
                     default:  init_done <= 1'b1;
                  endcase
                  cnt   <= '0;
                  state <= ST_GAP;
               end
            end
            ST_GAP: begin
               if (cnt_inc >= CW'(GAP_CYCLES)) begin
                  cnt <= '0;
                  // A timed-out config frame is resent as is.
                  if (!init_done) begin
                     state     <= ST_CFG_ISSUE;
                     spi_start <= 1'b1;
                  end else begin
`ifdef DAC161_LDAC_PULSE_EN
                     state <= ST_LDAC;
                     ldacb <= 1'b0;
`else
                     state <= ST_IDLE;
`endif
                  end
               end else begin
                  cnt <= cnt_inc;
               end
            end
`ifdef DAC161_LDAC_PULSE_EN
            ST_LDAC: begin
               if (cnt == CW'(1)) begin
                  ldacb <= 1'b1;
                  cnt   <= '0;
                  state <= ST_IDLE;
               end else begin
                  cnt <= cnt_inc;
               end
            end
`endif
            default: begin
               state <= ST_INIT_WAIT;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dac161_update_sched.sv
// Scoreboard bench for dac161_update_sched: stimulus queues the
// expected frames/completions, a monitor checks them at negedge.
`timescale 1ns/1ps
module tb_dac161_update_sched;

   localparam int INIT_C = 20;
   localparam int GAP_C  = 16;
   localparam int BTO    = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req0 = 1'b0;
   logic        req1 = 1'b0;
   logic [15:0] data0 = '0;
   logic [15:0] data1 = '0;
   logic        spi_busy = 1'b0;
   logic        ack0, ack1, spi_start, clrb, ldacb;
   logic        init_done, err;
   logic [23:0] spi_data;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int starts = 0;

   logic [23:0] exp_frames[$];
   int          exp_acks[$];

   bit model_on = 1'b1;
   int busy_len = 6;
   int fall_cyc = 0;
   bit gap_arm  = 1'b0;

   dac161_update_sched #(
      .INIT_CYCLES (INIT_C),
      .GAP_CYCLES  (GAP_C),
      .BUSY_TO     (BTO)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req0      (req0),
      .data0     (data0),
      .ack0      (ack0),
      .req1      (req1),
      .data1     (data1),
      .ack1      (ack1),
      .spi_start (spi_start),
      .spi_data  (spi_data),
      .spi_busy  (spi_busy),
      .clrb      (clrb),
      .ldacb     (ldacb),
      .init_done (init_done),
      .err       (err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic chk(input string name,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h",
                  name, got, exp);
      end
   endtask

   task automatic wait_for(input int which, input int bound,
                           output int n);
      bit hit;
      n = 0;
      hit = 1'b0;
      while (!hit && n < bound) begin
         @(posedge clk);
         #1;
         n++;
         case (which)
            0: hit = spi_start;
            1: hit = ack0;
            2: hit = ack1;
            3: hit = init_done;
            4: hit = err;
            5: hit = spi_busy;
            6: hit = !ldacb;
            default: hit = 1'b1;
         endcase
      end
      if (!hit) begin
         checks++;
         errors++;
         $display("FAIL wait_%0d: no event in %0d cycles",
                  which, bound);
         n = -1;
      end
   endtask

   task automatic take_ack(input int code);
      if (exp_acks.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL ack: unexpected completion %0d", code);
      end else begin
         chk("ack_src", code, exp_acks.pop_front());
      end
      chk("ack_at_fall", cyc - fall_cyc, 1);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_start"}, spi_start, 0);
      chk({tag, "_data"}, spi_data, 0);
      chk({tag, "_ack0"}, ack0, 0);
      chk({tag, "_ack1"}, ack1, 0);
      chk({tag, "_init"}, init_done, 0);
      chk({tag, "_err"}, err, 0);
      chk({tag, "_clrb"}, clrb, 1);
      chk({tag, "_ldacb"}, ldacb, 1);
   endtask

   task automatic do_req(input int who, input logic [15:0] d);
      int n;
      if (who == 0) begin
         data0 = d;
         req0 = 1'b1;
         wait_for(1, 300, n);
         req0 = 1'b0;
      end else begin
         data1 = d;
         req1 = 1'b1;
         wait_for(2, 300, n);
         req1 = 1'b0;
      end
   endtask

   // SPI master model: busy follows start unless disabled;
   // a reset aborts the frame without recording a busy fall.
   initial begin : spi_model
      forever begin
         @(negedge clk);
         if (spi_start && model_on && rst) begin
            spi_busy = 1'b1;
            for (int i = 0; i < busy_len && rst; i++)
               @(negedge clk);
            spi_busy = 1'b0;
            if (rst) begin
               fall_cyc = cyc;
               gap_arm  = 1'b1;
            end
         end
      end
   end

   initial begin : monitor
      logic p_init;
      logic p_ack0;
      logic p_ack1;
      logic p_rst;
      int   run;
      p_init = 1'b0;
      p_ack0 = 1'b0;
      p_ack1 = 1'b0;
      p_rst  = 1'b0;
      run    = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            if (spi_start) begin
               starts++;
               if (exp_frames.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL frame: unexpected start %h",
                           spi_data);
               end else begin
                  chk("frame", spi_data, exp_frames.pop_front());
               end
               if (gap_arm) begin
                  checks++;
                  if (cyc - fall_cyc < GAP_C) begin
                     errors++;
                     $display("FAIL gap: got %0d need >= %0d",
                              cyc - fall_cyc, GAP_C);
                  end
                  gap_arm = 1'b0;
               end
            end
            if (ack0) begin
               chk("ack0_pulse", p_ack0, 0);
               take_ack(0);
            end
            if (ack1) begin
               chk("ack1_pulse", p_ack1, 0);
               take_ack(1);
            end
            if (init_done && !p_init) take_ack(2);
         end else begin
            chk("ldacb_in_rst", ldacb, 1);
         end
`ifdef DAC161_LDAC_PULSE_EN
         if (rst && p_rst) begin
            if (!ldacb) begin
               run++;
            end else if (run > 0) begin
               chk("ldacb_low_len", run, 2);
               run = 0;
            end
         end else begin
            run = 0;
         end
`else
         if (rst && p_rst) chk("ldacb_held0", ldacb, 0);
`endif
         p_init = init_done;
         p_ack0 = ack0;
         p_ack1 = ack1;
         p_rst  = rst;
      end
   end

   initial begin : main
      int n;
      int s0;
      // T1: power-on reset, then the configuration frame.
      #1 rst = 1'b0;
      @(posedge clk);
      #2;
      chk_reset("por");
      exp_frames.push_back(24'h080000);
      exp_acks.push_back(2);
      @(negedge clk);
      #2 rst = 1'b1;
      wait_for(0, 60, n);
      chk("cfg_start_cycle", n, INIT_C + 1);
      chk("cfg_data", spi_data, 24'h080000);
      wait_for(3, 60, n);
      chk("init_done", init_done, 1);

      // T3: both requesters held -> 0,1,0,1.
      exp_frames.push_back(24'h011111);
      exp_frames.push_back(24'h012222);
      exp_frames.push_back(24'h013333);
      exp_frames.push_back(24'h014444);
      exp_acks.push_back(0);
      exp_acks.push_back(1);
      exp_acks.push_back(0);
      exp_acks.push_back(1);
      fork
         begin
            do_req(0, 16'h1111);
            do_req(0, 16'h3333);
         end
         begin
            do_req(1, 16'h2222);
            do_req(1, 16'h4444);
         end
      join

      // T2: single request from requester 0.
      exp_frames.push_back(24'h011234);
      exp_acks.push_back(0);
      do_req(0, 16'h1234);
`ifdef DAC161_LDAC_PULSE_EN
      wait_for(6, 40, n);
      chk("ldac_pulse_seen", ldacb, 0);
`endif

      // Foreign busy in IDLE blocks the grant.
      spi_busy = 1'b1;
      data1 = 16'hABCD;
      req1 = 1'b1;
      s0 = starts;
      repeat (40) @(posedge clk);
      #1;
      chk("busy_blocks_grant", starts - s0, 0);
      exp_frames.push_back(24'h01ABCD);
      exp_acks.push_back(1);
      spi_busy = 1'b0;
      wait_for(2, 60, n);
      req1 = 1'b0;
      chk("busy_release_ack1", ack1, 1);

      // T4: busy never rises -> err, no ack, retry.
      model_on = 1'b0;
      exp_frames.push_back(24'h01BEEF);
      exp_frames.push_back(24'h01BEEF);
      data0 = 16'hBEEF;
      req0 = 1'b1;
      wait_for(0, 60, n);
      wait_for(4, 20, n);
      chk("err_latency", n, BTO);
      chk("err_set", err, 1);
      model_on = 1'b1;
      exp_acks.push_back(0);
      wait_for(1, 100, n);
      req0 = 1'b0;
      chk("retry_ack0", ack0, 1);
      chk("err_sticky", err, 1);

      // T5: reset during WAIT_LO, restart with config frame.
      busy_len = 10;
      exp_frames.push_back(24'h015A5A);
      data0 = 16'h5A5A;
      req0 = 1'b1;
      wait_for(0, 60, n);
      wait_for(5, 10, n);
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;
      req0 = 1'b0;
      #1;
      chk_reset("midrst");
      busy_len = 4;
      exp_frames.push_back(24'h080000);
      exp_acks.push_back(2);
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      wait_for(0, 60, n);
      chk("rst2_start_cycle", n, INIT_C + 1);
      wait_for(3, 60, n);
      chk("rst2_init_done", init_done, 1);

      repeat (30) @(posedge clk);
      chk("frames_left", exp_frames.size(), 0);
      chk("acks_left", exp_acks.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
